// File: rtl/ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : ram_arbiter
// Brief    : Round-robin share of the SDRAM controller port between two camera
//            write ports and one readback port, with a data_ready timeout.
// Revision : 1.0
// ============================================================================
module ram_arbiter #(
    parameter int ADDR_W  = 26,
    parameter int TIMEOUT = 1023
) (
    input  logic              pixclk,
    input  logic              reset,
    input  logic              wa_req,
    input  logic [ADDR_W-1:0] wa_addr,
    input  logic [23:0]       wa_rgb,
    output logic              wa_ack,
    input  logic              wb_req,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [23:0]       wb_rgb,
    output logic              wb_ack,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_ack,
    output logic [23:0]       rd_rgb,
    output logic              err,
    output logic              busy,
    output logic              wr_ram,
    output logic              re_ram,
    output logic [ADDR_W-1:0] addr,
    output logic [7:0]        red,
    output logic [7:0]        green,
    output logic [7:0]        blue,
    input  logic              data_ready,
    input  logic [23:0]       rgb_in
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [1:0]  C_PORT_A  = 2'd0;
    localparam logic [1:0]  C_PORT_B  = 2'd1;
    localparam logic [1:0]  C_PORT_RD = 2'd2;
    localparam logic [15:0] C_TIMEOUT = 16'(TIMEOUT);
    localparam logic [15:0] C_CNT_MAX = 16'hFFFF;

    state_t              r_state_q;
    state_t              w_state_d;
    logic [1:0]          r_last_q;
    logic [1:0]          w_last_d;
    logic [1:0]          r_port_q;
    logic [1:0]          w_port_d;
    logic [15:0]         r_cnt_q;
    logic [15:0]         w_cnt_d;
    logic [ADDR_W-1:0]   r_addr_q;
    logic [ADDR_W-1:0]   w_addr_d;
    logic [23:0]         r_rgb_q;
    logic [23:0]         w_rgb_d;
    logic [23:0]         r_rd_rgb_q;
    logic [23:0]         w_rd_rgb_d;
    logic                r_wr_ram_q;
    logic                w_wr_ram_d;
    logic                r_re_ram_q;
    logic                w_re_ram_d;
    logic                r_wa_ack_q;
    logic                w_wa_ack_d;
    logic                r_wb_ack_q;
    logic                w_wb_ack_d;
    logic                r_rd_ack_q;
    logic                w_rd_ack_d;
    logic                r_err_q;
    logic                w_err_d;

    logic [2:0]          w_req;
    logic                w_grant_vld;
    logic [1:0]          w_grant_port;
    logic                w_finish;
    logic                w_abort;

    assign w_req = {rd_req, wb_req, wa_req};

    // Search begins at the port after the last one granted: A -> B -> RD -> A.
    always_comb begin
        w_grant_vld  = |w_req;
        w_grant_port = C_PORT_A;
        case (r_last_q)
            C_PORT_A: begin
                if (w_req[1])      w_grant_port = C_PORT_B;
                else if (w_req[2]) w_grant_port = C_PORT_RD;
                else               w_grant_port = C_PORT_A;
            end
            C_PORT_B: begin
                if (w_req[2])      w_grant_port = C_PORT_RD;
                else if (w_req[0]) w_grant_port = C_PORT_A;
                else               w_grant_port = C_PORT_B;
            end
            default: begin
                if (w_req[0])      w_grant_port = C_PORT_A;
                else if (w_req[1]) w_grant_port = C_PORT_B;
                else               w_grant_port = C_PORT_RD;
            end
        endcase
    end

    always_comb begin
        w_state_d  = r_state_q;
        w_last_d   = r_last_q;
        w_port_d   = r_port_q;
        w_cnt_d    = r_cnt_q;
        w_addr_d   = r_addr_q;
        w_rgb_d    = r_rgb_q;
        w_rd_rgb_d = r_rd_rgb_q;
        w_wr_ram_d = 1'b0;
        w_re_ram_d = 1'b0;
        w_finish   = 1'b0;
        w_abort    = 1'b0;

        case (r_state_q)
            ST_IDLE: begin
                if (w_grant_vld) begin
                    w_port_d  = w_grant_port;
                    w_state_d = ST_ISSUE;
                    case (w_grant_port)
                        C_PORT_A: begin
                            w_addr_d   = wa_addr;
                            w_rgb_d    = wa_rgb;
                            w_wr_ram_d = 1'b1;
                        end
                        C_PORT_B: begin
                            w_addr_d   = wb_addr;
                            w_rgb_d    = wb_rgb;
                            w_wr_ram_d = 1'b1;
                        end
                        default: begin
                            w_addr_d   = rd_addr;
                            w_re_ram_d = 1'b1;
                        end
                    endcase
                end
            end
            ST_ISSUE: begin
                w_cnt_d   = '0;
                w_state_d = ST_WAIT;
            end
            ST_WAIT: begin
                // A data_ready landing on the timeout cycle still counts as success.
                if (data_ready) begin
                    w_finish = 1'b1;
                    if (r_port_q == C_PORT_RD) begin
                        w_rd_rgb_d = rgb_in;
                    end
                end else if (r_cnt_q >= C_TIMEOUT) begin
                    w_finish = 1'b1;
                    w_abort  = 1'b1;
                end else if (r_cnt_q != C_CNT_MAX) begin
                    w_cnt_d = r_cnt_q + 16'd1;
                end
                if (w_finish) begin
                    w_state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                w_last_d  = r_port_q;
                w_state_d = ST_IDLE;
            end
            default: begin
                w_state_d = ST_IDLE;
            end
        endcase

        w_wa_ack_d = w_finish && (r_port_q == C_PORT_A);
        w_wb_ack_d = w_finish && (r_port_q == C_PORT_B);
        w_rd_ack_d = w_finish && (r_port_q == C_PORT_RD);
        w_err_d    = w_abort;
    end

    always_ff @(posedge pixclk) begin
        if (reset) begin
            r_state_q  <= ST_IDLE;
            r_last_q   <= C_PORT_RD;
            r_port_q   <= C_PORT_A;
            r_cnt_q    <= '0;
            r_addr_q   <= '0;
            r_rgb_q    <= '0;
            r_rd_rgb_q <= '0;
            r_wr_ram_q <= 1'b0;
            r_re_ram_q <= 1'b0;
            r_wa_ack_q <= 1'b0;
            r_wb_ack_q <= 1'b0;
            r_rd_ack_q <= 1'b0;
            r_err_q    <= 1'b0;
        end else begin
            r_state_q  <= w_state_d;
            r_last_q   <= w_last_d;
            r_port_q   <= w_port_d;
            r_cnt_q    <= w_cnt_d;
            r_addr_q   <= w_addr_d;
            r_rgb_q    <= w_rgb_d;
            r_rd_rgb_q <= w_rd_rgb_d;
            r_wr_ram_q <= w_wr_ram_d;
            r_re_ram_q <= w_re_ram_d;
            r_wa_ack_q <= w_wa_ack_d;
            r_wb_ack_q <= w_wb_ack_d;
            r_rd_ack_q <= w_rd_ack_d;
            r_err_q    <= w_err_d;
        end
    end

    assign wa_ack = r_wa_ack_q;
    assign wb_ack = r_wb_ack_q;
    assign rd_ack = r_rd_ack_q;
    assign err    = r_err_q;
    assign busy   = (r_state_q != ST_IDLE);
    assign wr_ram = r_wr_ram_q;
    assign re_ram = r_re_ram_q;
    assign addr   = r_addr_q;
    assign red    = r_rgb_q[23:16];
    assign green  = r_rgb_q[15:8];
    assign blue   = r_rgb_q[7:0];
    assign rd_rgb = r_rd_rgb_q;

endmodule
`default_nettype wire

// File: tb/tb_ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_ram_arbiter
// Brief    : Scoreboard bench for ram_arbiter with a behavioural controller.
// Revision : 1.0
// ============================================================================
module tb_ram_arbiter;

    localparam int ADDR_W  = 26;
    localparam int TIMEOUT = 8;

    logic              pixclk = 1'b0;
    logic              reset;
    logic              wa_req, wb_req, rd_req;
    logic [ADDR_W-1:0] wa_addr, wb_addr, rd_addr;
    logic [23:0]       wa_rgb, wb_rgb;
    logic              wa_ack, wb_ack, rd_ack;
    logic [23:0]       rd_rgb;
    logic              err, busy, wr_ram, re_ram;
    logic [ADDR_W-1:0] addr;
    logic [7:0]        red, green, blue;
    logic              data_ready;
    logic [23:0]       rgb_in;

    logic              ctrl_dr;
    logic              stray_dr;
    logic [23:0]       ctrl_rgb;
    bit                ctrl_en;
    int                ctrl_k;
    int                cyc = 0;
    int                n_checks = 0;
    int                n_errors = 0;

    assign data_ready = ctrl_dr | stray_dr;
    assign rgb_in     = ctrl_rgb;

    typedef struct {
        logic [2:0]  ack_oh;
        logic        err;
        logic [23:0] rgb;
        bit          chk_rgb;
    } exp_t;

    typedef struct {
        bit                got;
        logic [2:0]        acks;
        logic              err;
        logic              busy;
        logic [23:0]       rd_rgb;
        int                n_wr;
        int                n_re;
        int                strobe_cyc;
        int                ack_cyc;
        logic [ADDR_W-1:0] s_addr;
        logic [23:0]       s_rgb;
        logic [ADDR_W-1:0] ack_addr;
    } obs_t;

    exp_t sb[$];

    ram_arbiter #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
        .pixclk(pixclk), .reset(reset),
        .wa_req(wa_req), .wa_addr(wa_addr), .wa_rgb(wa_rgb), .wa_ack(wa_ack),
        .wb_req(wb_req), .wb_addr(wb_addr), .wb_rgb(wb_rgb), .wb_ack(wb_ack),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_ack(rd_ack), .rd_rgb(rd_rgb),
        .err(err), .busy(busy), .wr_ram(wr_ram), .re_ram(re_ram), .addr(addr),
        .red(red), .green(green), .blue(blue),
        .data_ready(data_ready), .rgb_in(rgb_in)
    );

    always #5 pixclk = ~pixclk;
    always @(posedge pixclk) cyc <= cyc + 1;

    // Controller model: answers a strobe seen in cycle S with data_ready in cycle S+k.
    initial begin
        ctrl_dr = 1'b0;
        forever begin
            @(negedge pixclk);
            if (ctrl_en && (wr_ram || re_ram)) begin
                repeat (ctrl_k) @(negedge pixclk);
                ctrl_dr = 1'b1;
                @(negedge pixclk);
                ctrl_dr = 1'b0;
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached, errors=%0d checks=%0d", n_errors, n_checks);
        $fatal(1, "watchdog");
    end

    task automatic run_until_ack(input int budget, input bit stray_at_strobe, output obs_t o);
        o = '{default: 0};
        o.strobe_cyc = -1;
        o.ack_cyc    = -1;
        for (int i = 0; i < budget && !o.got; i++) begin
            @(negedge pixclk);
            stray_dr = 1'b0;
            if (wr_ram || re_ram) begin
                if (wr_ram) o.n_wr++;
                if (re_ram) o.n_re++;
                o.strobe_cyc = cyc;
                o.s_addr     = addr;
                o.s_rgb      = {red, green, blue};
                if (stray_at_strobe) stray_dr = 1'b1;
            end
            if (wa_ack || wb_ack || rd_ack) begin
                o.got      = 1'b1;
                o.acks     = {rd_ack, wb_ack, wa_ack};
                o.err      = err;
                o.busy     = busy;
                o.rd_rgb   = rd_rgb;
                o.ack_cyc  = cyc;
                o.ack_addr = addr;
            end
        end
    endtask

    task automatic pop_exp(output exp_t e);
        if (sb.size() > 0) e = sb.pop_front();
        else e = '{ack_oh: 3'b000, err: 1'b0, rgb: 24'h0, chk_rgb: 1'b0};
    endtask

    task automatic test_reset();
        repeat (3) @(negedge pixclk);
        n_checks++;
        if ({busy, wa_ack, wb_ack, rd_ack, err, wr_ram, re_ram} !== 7'b0) begin
            n_errors++;
            $display("FAIL reset_ctrl: {busy,acks,err,wr,re}=%b expected 0000000",
                     {busy, wa_ack, wb_ack, rd_ack, err, wr_ram, re_ram});
        end
        n_checks++;
        if (addr !== '0 || {red, green, blue} !== 24'h0 || rd_rgb !== 24'h0) begin
            n_errors++;
            $display("FAIL reset_data: addr=%h rgb=%h rd_rgb=%h expected all zero",
                     addr, {red, green, blue}, rd_rgb);
        end
        reset = 1'b0;
    endtask

    task automatic test_single_write();
        obs_t o; exp_t e; int req_cyc;
        ctrl_en = 1'b1; ctrl_k = 3;
        wa_addr = 26'h0001234; wa_rgb = 24'hA1B2C3; wa_req = 1'b1;
        req_cyc = cyc;
        sb.push_back('{ack_oh: 3'b001, err: 1'b0, rgb: 24'h0, chk_rgb: 1'b0});
        run_until_ack(20, 1'b0, o);
        wa_req = 1'b0;
        pop_exp(e);
        n_checks++;
        if (!o.got || o.acks !== e.ack_oh) begin
            n_errors++; $display("FAIL wr_ack: got=%0d acks=%b expected %b", o.got, o.acks, e.ack_oh);
        end
        n_checks++;
        if (o.n_wr !== 1 || o.n_re !== 0) begin
            n_errors++; $display("FAIL wr_strobes: wr=%0d re=%0d expected 1/0", o.n_wr, o.n_re);
        end
        n_checks++;
        if (o.s_addr !== 26'h0001234 || o.ack_addr !== 26'h0001234) begin
            n_errors++; $display("FAIL wr_addr: issue=%h done=%h expected 0001234", o.s_addr, o.ack_addr);
        end
        n_checks++;
        if (o.s_rgb !== 24'hA1B2C3) begin
            n_errors++; $display("FAIL wr_rgb: %h expected a1b2c3", o.s_rgb);
        end
        n_checks++;
        if (o.strobe_cyc !== req_cyc + 1) begin
            n_errors++; $display("FAIL wr_strobe_lat: cycle %0d expected %0d", o.strobe_cyc, req_cyc + 1);
        end
        n_checks++;
        if ((o.ack_cyc - o.strobe_cyc) !== ctrl_k + 1) begin
            n_errors++; $display("FAIL wr_ack_lat: %0d expected %0d", o.ack_cyc - o.strobe_cyc, ctrl_k + 1);
        end
        n_checks++;
        if (o.err !== e.err || o.busy !== 1'b1) begin
            n_errors++; $display("FAIL wr_done_flags: err=%b busy=%b expected 0/1", o.err, o.busy);
        end
        @(negedge pixclk);
        n_checks++;
        if (busy !== 1'b0 || addr !== 26'h0001234 || {wa_ack, wb_ack, rd_ack} !== 3'b000) begin
            n_errors++; $display("FAIL wr_idle_hold: busy=%b addr=%h acks=%b expected 0/0001234/000",
                                 busy, addr, {rd_ack, wb_ack, wa_ack});
        end
    endtask

    task automatic test_read();
        obs_t o; exp_t e;
        ctrl_en = 1'b1; ctrl_k = 2; ctrl_rgb = 24'h102030;
        rd_addr = 26'h3FFFFFF; rd_req = 1'b1;
        sb.push_back('{ack_oh: 3'b100, err: 1'b0, rgb: 24'h102030, chk_rgb: 1'b1});
        run_until_ack(20, 1'b0, o);
        rd_req = 1'b0;
        pop_exp(e);
        n_checks++;
        if (!o.got || o.acks !== e.ack_oh) begin
            n_errors++; $display("FAIL rd_ack: got=%0d acks=%b expected %b", o.got, o.acks, e.ack_oh);
        end
        n_checks++;
        if (o.n_re !== 1 || o.n_wr !== 0 || o.s_addr !== 26'h3FFFFFF) begin
            n_errors++; $display("FAIL rd_issue: re=%0d wr=%0d addr=%h expected 1/0/3ffffff",
                                 o.n_re, o.n_wr, o.s_addr);
        end
        n_checks++;
        if (o.rd_rgb !== e.rgb || o.err !== e.err) begin
            n_errors++; $display("FAIL rd_data: rd_rgb=%h err=%b expected %h/%b", o.rd_rgb, o.err, e.rgb, e.err);
        end
        ctrl_rgb = 24'hEEEEEE;
        repeat (3) @(negedge pixclk);
        n_checks++;
        if (rd_rgb !== 24'h102030 || busy !== 1'b0) begin
            n_errors++; $display("FAIL rd_hold: rd_rgb=%h busy=%b expected 102030/0", rd_rgb, busy);
        end
    endtask

    task automatic test_timeout();
        obs_t o; exp_t e;
        ctrl_en = 1'b0; ctrl_rgb = 24'h5A5A5A;
        rd_addr = 26'h0000777; rd_req = 1'b1;
        sb.push_back('{ack_oh: 3'b100, err: 1'b1, rgb: 24'h102030, chk_rgb: 1'b1});
        run_until_ack(40, 1'b0, o);
        rd_req = 1'b0;
        pop_exp(e);
        n_checks++;
        if (!o.got || o.acks !== e.ack_oh || o.err !== e.err) begin
            n_errors++; $display("FAIL to_ack_err: got=%0d acks=%b err=%b expected %b/%b",
                                 o.got, o.acks, o.err, e.ack_oh, e.err);
        end
        n_checks++;
        if ((o.ack_cyc - o.strobe_cyc) !== TIMEOUT + 2) begin
            n_errors++; $display("FAIL to_latency: %0d expected %0d", o.ack_cyc - o.strobe_cyc, TIMEOUT + 2);
        end
        n_checks++;
        if (o.rd_rgb !== e.rgb || o.n_re !== 1) begin
            n_errors++; $display("FAIL to_rd_rgb: rd_rgb=%h re=%0d expected %h/1", o.rd_rgb, o.n_re, e.rgb);
        end
        @(negedge pixclk);
        n_checks++;
        if (err !== 1'b0 || {wa_ack, wb_ack, rd_ack} !== 3'b000) begin
            n_errors++; $display("FAIL to_pulse_width: err=%b acks=%b expected 0/000", err, {rd_ack, wb_ack, wa_ack});
        end
        ctrl_en = 1'b1; ctrl_k = 2; ctrl_rgb = 24'h0F0E0D;
        wb_addr = 26'h2ABCDEF; wb_rgb = 24'h778899; wb_req = 1'b1;
        sb.push_back('{ack_oh: 3'b010, err: 1'b0, rgb: 24'h0, chk_rgb: 1'b0});
        run_until_ack(20, 1'b0, o);
        wb_req = 1'b0;
        pop_exp(e);
        n_checks++;
        if (!o.got || o.acks !== e.ack_oh || o.err !== e.err) begin
            n_errors++; $display("FAIL to_next_ack: got=%0d acks=%b err=%b expected %b/%b",
                                 o.got, o.acks, o.err, e.ack_oh, e.err);
        end
        n_checks++;
        if (o.s_addr !== 26'h2ABCDEF || o.s_rgb !== 24'h778899 || (o.ack_cyc - o.strobe_cyc) !== 3) begin
            n_errors++; $display("FAIL to_next_data: addr=%h rgb=%h lat=%0d expected 2abcdef/778899/3",
                                 o.s_addr, o.s_rgb, o.ack_cyc - o.strobe_cyc);
        end
    endtask

    task automatic test_round_robin();
        obs_t o; exp_t e; int prev_ack; int extra; logic [ADDR_W-1:0] exp_addr;
        reset = 1'b1;
        @(negedge pixclk);
        reset = 1'b0;
        ctrl_en = 1'b1; ctrl_k = 1; ctrl_rgb = 24'h333333;
        wa_addr = 26'h0000010; wb_addr = 26'h0000020; rd_addr = 26'h0000030;
        wa_rgb = 24'h111111; wb_rgb = 24'h222222;
        wa_req = 1'b1; wb_req = 1'b1; rd_req = 1'b1;
        for (int n = 0; n < 6; n++) begin
            case (n % 3)
                0:       sb.push_back('{ack_oh: 3'b001, err: 1'b0, rgb: 24'h0, chk_rgb: 1'b0});
                1:       sb.push_back('{ack_oh: 3'b010, err: 1'b0, rgb: 24'h0, chk_rgb: 1'b0});
                default: sb.push_back('{ack_oh: 3'b100, err: 1'b0, rgb: 24'h333333, chk_rgb: 1'b1});
            endcase
        end
        prev_ack = 0;
        for (int n = 0; n < 6; n++) begin
            run_until_ack(30, 1'b0, o);
            if (n == 5) begin
                wa_req = 1'b0; wb_req = 1'b0; rd_req = 1'b0;
            end
            pop_exp(e);
            exp_addr = e.ack_oh[0] ? 26'h0000010 : (e.ack_oh[1] ? 26'h0000020 : 26'h0000030);
            n_checks++;
            if (!o.got || o.acks !== e.ack_oh) begin
                n_errors++; $display("FAIL rr_grant[%0d]: got=%0d acks=%b expected %b", n, o.got, o.acks, e.ack_oh);
            end
            n_checks++;
            if (o.n_wr !== (e.ack_oh[2] ? 0 : 1) || o.n_re !== (e.ack_oh[2] ? 1 : 0) || o.s_addr !== exp_addr) begin
                n_errors++; $display("FAIL rr_issue[%0d]: wr=%0d re=%0d addr=%h expected addr %h",
                                     n, o.n_wr, o.n_re, o.s_addr, exp_addr);
            end
            if (e.chk_rgb) begin
                n_checks++;
                if (o.rd_rgb !== e.rgb) begin
                    n_errors++; $display("FAIL rr_rd_rgb[%0d]: %h expected %h", n, o.rd_rgb, e.rgb);
                end
            end
            if (n > 0) begin
                n_checks++;
                if ((o.ack_cyc - prev_ack) !== ctrl_k + 3) begin
                    n_errors++; $display("FAIL rr_spacing[%0d]: %0d expected %0d", n, o.ack_cyc - prev_ack, ctrl_k + 3);
                end
            end
            prev_ack = o.ack_cyc;
        end
        extra = 0;
        repeat (8) begin
            @(negedge pixclk);
            if (wr_ram || re_ram || wa_ack || wb_ack || rd_ack || busy) extra++;
        end
        n_checks++;
        if (extra !== 0) begin
            n_errors++; $display("FAIL rr_quiet: %0d active cycles expected 0", extra);
        end
    endtask

    task automatic test_reset_mid();
        obs_t o; exp_t e; bit found; int noisy;
        ctrl_en = 1'b1; ctrl_k = 2;
        wa_addr = 26'h0000ABC; wa_rgb = 24'h010203; wa_req = 1'b1;
        sb.push_back('{ack_oh: 3'b001, err: 1'b0, rgb: 24'h0, chk_rgb: 1'b0});
        run_until_ack(20, 1'b0, o);
        wa_req = 1'b0;
        pop_exp(e);
        n_checks++;
        if (!o.got || o.acks !== e.ack_oh) begin
            n_errors++; $display("FAIL mid_pre_ack: acks=%b expected %b", o.acks, e.ack_oh);
        end
        ctrl_en = 1'b0;
        wb_addr = 26'h0000BBB; wb_rgb = 24'hBBBBBB; wb_req = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            @(negedge pixclk);
            if (wr_ram) found = 1'b1;
        end
        repeat (2) @(negedge pixclk);
        n_checks++;
        if (!found || busy !== 1'b1) begin
            n_errors++; $display("FAIL mid_in_wait: strobe_seen=%0d busy=%b expected 1/1", found, busy);
        end
        reset = 1'b1; wb_req = 1'b0;
        @(negedge pixclk);
        n_checks++;
        if ({busy, wa_ack, wb_ack, rd_ack, err, wr_ram, re_ram} !== 7'b0 || addr !== '0 ||
            {red, green, blue} !== 24'h0 || rd_rgb !== 24'h0) begin
            n_errors++; $display("FAIL mid_reset_vals: ctrl=%b addr=%h rgb=%h rd_rgb=%h expected zeros",
                                 {busy, wa_ack, wb_ack, rd_ack, err, wr_ram, re_ram}, addr, {red, green, blue}, rd_rgb);
        end
        reset = 1'b0; stray_dr = 1'b1;
        noisy = 0;
        repeat (6) begin
            @(negedge pixclk);
            stray_dr = 1'b0;
            if (busy || wa_ack || wb_ack || rd_ack || err || wr_ram || re_ram) noisy++;
        end
        n_checks++;
        if (noisy !== 0) begin
            n_errors++; $display("FAIL mid_no_ack: %0d active cycles expected 0", noisy);
        end
        ctrl_en = 1'b1; ctrl_k = 1;
        wa_req = 1'b1; wb_req = 1'b1; rd_req = 1'b1;
        sb.push_back('{ack_oh: 3'b001, err: 1'b0, rgb: 24'h0, chk_rgb: 1'b0});
        run_until_ack(20, 1'b0, o);
        wa_req = 1'b0; wb_req = 1'b0; rd_req = 1'b0;
        pop_exp(e);
        n_checks++;
        if (!o.got || o.acks !== e.ack_oh || o.s_addr !== 26'h0000ABC) begin
            n_errors++; $display("FAIL mid_first_grant: acks=%b addr=%h expected %b/0000abc", o.acks, o.s_addr, e.ack_oh);
        end
        @(negedge pixclk);
    endtask

    task automatic test_stray_ready();
        obs_t o; exp_t e; int noisy;
        ctrl_en = 1'b1; ctrl_k = 3; ctrl_rgb = 24'h445566;
        stray_dr = 1'b1;
        noisy = 0;
        repeat (3) begin
            @(negedge pixclk);
            stray_dr = 1'b0;
            if (busy || wa_ack || wb_ack || rd_ack || err) noisy++;
        end
        n_checks++;
        if (noisy !== 0) begin
            n_errors++; $display("FAIL stray_idle: %0d active cycles expected 0", noisy);
        end
        rd_addr = 26'h1555555; rd_req = 1'b1;
        sb.push_back('{ack_oh: 3'b100, err: 1'b0, rgb: 24'h445566, chk_rgb: 1'b1});
        run_until_ack(20, 1'b1, o);
        rd_req = 1'b0;
        pop_exp(e);
        n_checks++;
        if (!o.got || o.acks !== e.ack_oh || o.err !== e.err) begin
            n_errors++; $display("FAIL stray_ack: acks=%b err=%b expected %b/%b", o.acks, o.err, e.ack_oh, e.err);
        end
        n_checks++;
        if ((o.ack_cyc - o.strobe_cyc) !== ctrl_k + 1) begin
            n_errors++; $display("FAIL stray_latency: %0d expected %0d", o.ack_cyc - o.strobe_cyc, ctrl_k + 1);
        end
        n_checks++;
        if (o.rd_rgb !== e.rgb || o.s_addr !== 26'h1555555) begin
            n_errors++; $display("FAIL stray_data: rd_rgb=%h addr=%h expected %h/1555555", o.rd_rgb, o.s_addr, e.rgb);
        end
    endtask

    initial begin
        reset    = 1'b1;
        wa_req   = 1'b0; wb_req = 1'b0; rd_req = 1'b0;
        wa_addr  = '0;   wb_addr = '0;  rd_addr = '0;
        wa_rgb   = '0;   wb_rgb  = '0;
        ctrl_en  = 1'b0; ctrl_k  = 1;   ctrl_rgb = '0;
        stray_dr = 1'b0;

        test_reset();
        test_single_write();
        test_read();
        test_timeout();
        test_round_robin();
        test_reset_mid();
        test_stray_ready();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ram_arbiter.md
# ram_arbiter

Shares the single SDRAM Ram_Controller port between three requesters: left-camera write, right-camera write, and one read port for UART readback or video. Each transaction is granted round-robin and issued as a one-cycle wr_ram or re_ram strobe with latched address and RGB data. The block then waits for the controller's data_ready and acknowledges the requester. It sits between the capture/serial logic and Ram_Controller in the ulx3s top level.

## Interface
- ADDR_W, 26, SDRAM pixel address width
- TIMEOUT, 1023, max cycles to wait for data_ready before abort (1..65535)
- pixclk  in  1  system clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- wa_req, wb_req  in  1 each  write requests, ports A (left cam) / B (right cam)
- wa_addr, wb_addr  in  ADDR_W each  write addresses
- wa_rgb, wb_rgb  in  24 each  write pixel {R[23:16],G[15:8],B[7:0]}
- wa_ack, wb_ack  out  1 each  one-cycle write-complete pulse
- rd_req  in  1  read request
- rd_addr  in  ADDR_W  read address
- rd_ack  out  1  one-cycle read-complete pulse; rd_rgb valid the same cycle
- rd_rgb  out  24  read pixel, held until next read completes
- err  out  1  one-cycle pulse with ack when a transaction timed out
- busy  out  1  high whenever state is not IDLE
- wr_ram, re_ram  out  1 each  strobes to Ram_Controller
- addr  out  ADDR_W  address to controller
- red, green, blue  out  8 each  write data to controller
- data_ready  in  1  controller completion
- rgb_in  in  24  controller read data

## Operation
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE: if any request is high, grant per round-robin and latch the granted addr/rgb and the op type. Go to ISSUE.
  - Round-robin order is A -> B -> RD -> A. Search starts at the port after the last granted port.
  - After reset, the last granted port is RD, so A has first priority.
- ISSUE: assert exactly one of wr_ram/re_ram for one cycle. Clear the timeout counter. Go to WAIT.
- WAIT: count cycles.
  - On data_ready: if the op is a read, capture rgb_in into rd_rgb; go to DONE.
  - If the counter reaches TIMEOUT without data_ready: set the abort flag; go to DONE. rd_rgb is unchanged.
  - data_ready outside WAIT is ignored.
- DONE: pulse the granted port's ack. Pulse err if aborted. Update the last granted port. Return to IDLE.
- Request protocol:
  - The requester holds req, addr and rgb stable until its ack.
  - The requester drops req in the cycle after ack, or keeps it high to request again.
  - The arbiter samples req only in IDLE, so a request that is still high in the IDLE cycle following DONE is a new transaction.
- addr/red/green/blue hold the latched values from ISSUE through DONE. They hold their last value in IDLE.
- Counter width is 16 bits; it saturates and does not wrap.

## Timing
- Reset values:
  - state IDLE
  - all acks, err, wr_ram, re_ram = 0
  - busy = 0
  - addr = 0, red/green/blue = 0, rd_rgb = 0
  - last granted port = RD
- Request seen in IDLE at edge t:
  - ISSUE during cycle t+1, strobe high for cycle t+1 only.
  - WAIT from t+2.
  - data_ready sampled in cycle t+1+k (k>=1) puts DONE in cycle t+2+k, with ack that cycle.
  - IDLE at t+3+k.
- Minimum req-to-ack: 4 cycles. Back-to-back transactions: one every k+3 cycles.
- Timeout: ack+err in cycle t+2+TIMEOUT+1.
- Reset mid-transaction (any state): next cycle in IDLE with all outputs at reset values. No ack or err is issued for the killed transaction.
- Simultaneous requests: exactly one grant; the others wait with req held.

## Test plan
- Single write on A (addr 0x0001234, rgb 0xA1B2C3), data_ready 3 cycles after strobe -> one wr_ram pulse; addr=0x0001234, red=0xA1, green=0xB2, blue=0xC3; wa_ack 1 cycle after data_ready; no other ack.
- Read, rd_addr 0x3FFFFFF, controller returns rgb_in=0x102030 with data_ready -> re_ram single pulse, addr=0x3FFFFFF; rd_ack with rd_rgb=0x102030, which holds afterwards.
- wa_req, wb_req and rd_req all held high, 6 transactions after reset -> grant order A,B,RD,A,B,RD; acks never overlap; exactly one strobe per transaction.
- TIMEOUT=8, data_ready never asserted -> ack and err pulse together 10 cycles after the strobe cycle; rd_rgb unchanged; next request proceeds normally.
- Reset asserted in WAIT, then data_ready arrives -> no ack, busy=0, no strobe; the subsequent request is granted to A first.
- data_ready pulsed while IDLE, plus a stray pulse during ISSUE -> ignored; the transaction completes only on the data_ready inside WAIT.
